// File: rtl/avst_packet_channel_mux_pkg.sv
// ---------------------------------------------------------------------------
// avst_pkg
// Shared definitions for the Avalon-ST packet channel multiplexer:
//   - MAX_NUM_IN   : largest supported number of input streams
//   - lock_state_e : arbitration state (UNLOCKED / LOCKED to one owner)
//   - clog2        : ceiling log2, usable in parameter expressions
//   - idx_width    : width of an input index (at least one bit)
// ---------------------------------------------------------------------------
package avst_pkg;

    localparam int MAX_NUM_IN = 16;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // A single-input mux still needs a one-bit index register.
    function automatic int idx_width(input int num_in);
        return (clog2(num_in) < 1) ? 1 : clog2(num_in);
    endfunction

endpackage

// File: rtl/avst_packet_channel_mux_if.sv
// ---------------------------------------------------------------------------
// avst_packet_channel_mux_if
// Bundles the streaming and status signals of avst_packet_channel_mux.
//   in_valid / in_ready / in_data / in_startofpacket / in_endofpacket :
//       NUM_IN sink streams, input i data in bits [i*DATA_W +: DATA_W]
//   out_ready / out_valid / out_data / out_startofpacket /
//   out_endofpacket / out_channel : merged source stream
//   err_sop / err_nosop_clear : sticky missing-SOP flag and its clear
//   dbg_state : current arbitration state, for observation only
//
// Handshake: a beat transfers on a rising clk edge exactly when valid and
// ready are both high; ready latency is 0, valid never waits on ready,
// and payload is only meaningful while valid is high.
//
// Modports: slave = the multiplexer, master = the environment driving it.
// ---------------------------------------------------------------------------
interface avst_packet_channel_mux_if #(
    parameter int NUM_IN    = 2,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_startofpacket;
    logic [NUM_IN-1:0]        in_endofpacket;
    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_startofpacket;
    logic                     out_endofpacket;
    logic [CHANNEL_W-1:0]     out_channel;
    logic                     err_sop;
    logic                     err_nosop_clear;
    avst_pkg::lock_state_e    dbg_state;

    modport slave (
        input  in_valid, in_data, in_startofpacket, in_endofpacket,
        input  out_ready, err_nosop_clear,
        output in_ready, out_valid, out_data, out_startofpacket,
        output out_endofpacket, out_channel, err_sop, dbg_state
    );

    modport master (
        output in_valid, in_data, in_startofpacket, in_endofpacket,
        output out_ready, err_nosop_clear,
        input  in_ready, out_valid, out_data, out_startofpacket,
        input  out_endofpacket, out_channel, err_sop, dbg_state
    );
endinterface

// File: rtl/avst_packet_channel_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// avst_rr_arbiter
// Purely combinational round-robin arbiter with packet lock.
//   i_req       : request vector (per-input valid)
//   i_rr_ptr    : index granted most recently; search starts one above it
//   i_lock      : a packet is in progress, grant only i_owner
//   i_owner     : input that owns the current packet
//   o_grant     : one-hot grant (all zero when unlocked and nobody asks)
//   o_grant_idx : encoded index of the granted input
// ---------------------------------------------------------------------------
module avst_rr_arbiter #(
    parameter int NUM_IN = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [IDX_W-1:0]  i_rr_ptr,
    input  logic              i_lock,
    input  logic [IDX_W-1:0]  i_owner,
    output logic [NUM_IN-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grant_idx
);
    logic w_found;

    // The circular search rr_ptr+1, rr_ptr+2, ... is done as two linear
    // passes: first the inputs above rr_ptr, then the inputs up to it.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        if (i_lock) begin
            // Owner keeps the grant even while its valid is low.
            for (int j = 0; j < NUM_IN; j++) begin
                if (IDX_W'(j) == i_owner) begin
                    o_grant[j] = 1'b1;
                end
            end
            o_grant_idx = i_owner;
        end else begin
            for (int j = 0; j < NUM_IN; j++) begin
                if (!w_found && i_req[j] && (j > int'(i_rr_ptr))) begin
                    w_found     = 1'b1;
                    o_grant[j]  = 1'b1;
                    o_grant_idx = IDX_W'(j);
                end
            end
            for (int j = 0; j < NUM_IN; j++) begin
                if (!w_found && i_req[j] && (j <= int'(i_rr_ptr))) begin
                    w_found     = 1'b1;
                    o_grant[j]  = 1'b1;
                    o_grant_idx = IDX_W'(j);
                end
            end
        end
    end
endmodule

// File: rtl/avst_packet_channel_mux.sv
// ---------------------------------------------------------------------------
// avst_packet_channel_mux
// Merges NUM_IN Avalon-ST packet streams into one stream, tagging every
// beat with its source index on out_channel. Arbitration is round robin
// between packets; once a multi-beat packet starts its input keeps the
// grant until EOP. The output is a single register stage (latency 1,
// full throughput while out_ready is high).
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : streaming/status signals (avst_packet_channel_mux_if)
// err_sop is sticky: it records a beat accepted without SOP while no
// packet was in progress; err_nosop_clear clears it (a new error wins).
// ---------------------------------------------------------------------------
module avst_packet_channel_mux
    import avst_pkg::*;
#(
    parameter int NUM_IN    = 2,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    avst_packet_channel_mux_if.slave bus
);
    localparam int               IDX_W    = idx_width(NUM_IN);
    localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_IN - 1);

    lock_state_e          r_state;
    lock_state_e          w_state_nxt;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     w_owner_nxt;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     w_rr_nxt;
    logic                 r_err_sop;
    logic                 w_err_set;

    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_out_sop;
    logic                 r_out_eop;
    logic [CHANNEL_W-1:0] r_out_channel;

    logic [NUM_IN-1:0]    w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [NUM_IN-1:0]    w_in_ready;
    logic                 w_locked;
    logic                 w_load;
    logic                 w_accept;
    logic [DATA_W-1:0]    w_beat_data;
    logic                 w_beat_sop;
    logic                 w_beat_eop;

    assign w_locked = (r_state == ST_LOCKED);

    avst_rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_arbiter (
        .i_req       (bus.in_valid),
        .i_rr_ptr    (r_rr_ptr),
        .i_lock      (w_locked),
        .i_owner     (r_owner),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // The output register can take a beat when empty or being drained.
    assign w_load     = ~r_out_valid | bus.out_ready;
    assign w_in_ready = {NUM_IN{w_load}} & w_grant;
    assign w_accept   = |(bus.in_valid & w_in_ready);

    // Payload of the granted input (grant is one-hot).
    always_comb begin
        w_beat_data = '0;
        w_beat_sop  = 1'b0;
        w_beat_eop  = 1'b0;
        for (int j = 0; j < NUM_IN; j++) begin
            if (w_grant[j]) begin
                w_beat_data = bus.in_data[j*DATA_W +: DATA_W];
                w_beat_sop  = bus.in_startofpacket[j];
                w_beat_eop  = bus.in_endofpacket[j];
            end
        end
    end

    // Lock FSM: next state, owner, round-robin pointer and error set.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_err_set   = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_UNLOCKED: begin
                    w_rr_nxt  = w_grant_idx;
                    // A beat without SOP is still forwarded; it is framed
                    // as if it started a packet so the stream stays atomic.
                    w_err_set = ~w_beat_sop;
                    if (!w_beat_eop) begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_grant_idx;
                    end
                end
                ST_LOCKED: begin
                    if (w_beat_eop) begin
                        w_state_nxt = ST_UNLOCKED;
                    end
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_UNLOCKED;
            r_owner   <= '0;
            r_rr_ptr  <= RR_RESET;
            r_err_sop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_rr_nxt;
            // Set has priority over a simultaneous clear.
            r_err_sop <= (r_err_sop & ~bus.err_nosop_clear) | w_err_set;
        end
    end

    // Output stage: payload fields only change when a beat is loaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_channel <= '0;
        end else if (w_load) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data    <= w_beat_data;
                r_out_sop     <= w_beat_sop;
                r_out_eop     <= w_beat_eop;
                r_out_channel <= CHANNEL_W'(w_grant_idx);
            end
        end
    end

    assign bus.in_ready          = w_in_ready;
    assign bus.out_valid         = r_out_valid;
    assign bus.out_data          = r_out_data;
    assign bus.out_startofpacket = r_out_sop;
    assign bus.out_endofpacket   = r_out_eop;
    assign bus.out_channel       = r_out_channel;
    assign bus.err_sop           = r_err_sop;
    assign bus.dbg_state         = r_state;

endmodule

// File: tb/tb_avst_packet_channel_mux.sv
// ---------------------------------------------------------------------------
// tb_avst_packet_channel_mux
// Two instances: u_dut2 (2 inputs, 8-bit channel) and u_dut4 (4 inputs,
// 2-bit channel). Each input is fed from a small beat table; a reference
// model of the arbitration rules predicts in_ready and the output register
// every cycle, and a scoreboard checks the merged beat order against
// hand-written expectations.
// ---------------------------------------------------------------------------
module tb_avst_packet_channel_mux;
    import avst_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    avst_packet_channel_mux_if #(.NUM_IN(2), .DATA_W(8), .CHANNEL_W(8)) bus2 ();
    avst_packet_channel_mux_if #(.NUM_IN(4), .DATA_W(8), .CHANNEL_W(2)) bus4 ();

    avst_packet_channel_mux #(.NUM_IN(2), .DATA_W(8), .CHANNEL_W(8)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    avst_packet_channel_mux #(.NUM_IN(4), .DATA_W(8), .CHANNEL_W(2)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    // ---------------- bookkeeping ----------------
    int n_checks;
    int n_errs;

    logic [15:0] exp_q2[$];   // {channel, data} expected on u_dut2
    logic [15:0] exp_q4[$];   // {channel, data} expected on u_dut4

    // Source tables: slots 0..1 feed u_dut2, slots 2..5 feed u_dut4.
    logic [9:0] src_mem[6][32];  // {sop, eop, data}
    int         src_len[6];
    int         src_pos[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int s, input logic sop, input logic eop, input logic [7:0] data);
        src_mem[s][src_len[s]] = {sop, eop, data};
        src_len[s]++;
    endtask

    function automatic bit sources_busy();
        bit busy;
        busy = 1'b0;
        for (int s = 0; s < 6; s++) begin
            if (src_pos[s] < src_len[s]) busy = 1'b1;
        end
        return busy;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_inputs();
        logic [1:0]  v2, s2, e2;
        logic [15:0] d2;
        logic [3:0]  v4, s4, e4;
        logic [31:0] d4;
        for (int i = 0; i < 2; i++) begin
            if (src_pos[i] < src_len[i]) begin
                v2[i] = 1'b1;
                {s2[i], e2[i], d2[i*8 +: 8]} = src_mem[i][src_pos[i]];
            end else begin
                // Payload of an idle input is garbage on purpose.
                v2[i] = 1'b0;
                s2[i] = 1'($urandom_range(0, 1));
                e2[i] = 1'($urandom_range(0, 1));
                d2[i*8 +: 8] = 8'($urandom_range(0, 255));
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (src_pos[i+2] < src_len[i+2]) begin
                v4[i] = 1'b1;
                {s4[i], e4[i], d4[i*8 +: 8]} = src_mem[i+2][src_pos[i+2]];
            end else begin
                v4[i] = 1'b0;
                s4[i] = 1'($urandom_range(0, 1));
                e4[i] = 1'($urandom_range(0, 1));
                d4[i*8 +: 8] = 8'($urandom_range(0, 255));
            end
        end
        bus2.in_valid = v2; bus2.in_startofpacket = s2; bus2.in_endofpacket = e2; bus2.in_data = d2;
        bus4.in_valid = v4; bus4.in_startofpacket = s4; bus4.in_endofpacket = e4; bus4.in_data = d4;
    endtask

    // Handshakes are decided on the falling edge and retired after the
    // following rising edge.
    logic [1:0] fire2;
    logic [3:0] fire4;
    always begin
        @(negedge clk);
        fire2 = reset_n ? (bus2.in_valid & bus2.in_ready) : 2'b00;
        fire4 = reset_n ? (bus4.in_valid & bus4.in_ready) : 4'b0000;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (fire2[i] && src_pos[i] < src_len[i]) src_pos[i]++;
        for (int i = 0; i < 4; i++) if (fire4[i] && src_pos[i+2] < src_len[i+2]) src_pos[i+2]++;
        drive_inputs();
    end

    // ---------------- reference model ----------------
    // Per instance: whether a packet is in progress and its owner, the
    // last input that started a transfer, the sticky error and the
    // contents of the output register.
    bit         m_pkt[2];
    int         m_own[2];
    int         m_last[2];
    bit         m_err[2];
    bit         m_ov[2];
    logic [7:0] m_od[2];
    bit         m_os[2];
    bit         m_oe[2];
    int         m_och[2];

    task automatic model_cycle(
        input int d, input int n, input logic rst,
        input logic [3:0] iv, input logic [3:0] ir, input logic [3:0] isop, input logic [3:0] ieop,
        input logic [31:0] idat, input logic ordy,
        input logic ov, input logic [7:0] od, input logic os, input logic oe, input logic [7:0] och,
        input logic err, input logic clr);
        int         g;
        bit         space;
        bit         setv;
        logic [3:0] mask;
        logic [3:0] exp_rdy;
        string      t;
        t = (d == 0) ? "m2" : "m4";
        if (!rst) begin
            check({t, "_rst_valid"}, ov, 0);
            check({t, "_rst_data"}, od, 0);
            check({t, "_rst_sop"}, os, 0);
            check({t, "_rst_eop"}, oe, 0);
            check({t, "_rst_channel"}, och, 0);
            check({t, "_rst_err"}, err, 0);
            m_pkt[d] = 0; m_own[d] = 0; m_last[d] = n - 1; m_err[d] = 0;
            m_ov[d] = 0; m_od[d] = 0; m_os[d] = 0; m_oe[d] = 0; m_och[d] = 0;
            return;
        end
        check({t, "_out_valid"}, ov, m_ov[d]);
        if (m_ov[d]) begin
            check({t, "_out_data"}, od, m_od[d]);
            check({t, "_out_sop"}, os, m_os[d]);
            check({t, "_out_eop"}, oe, m_oe[d]);
            check({t, "_out_channel"}, och, m_och[d]);
        end
        check({t, "_err_sop"}, err, m_err[d]);

        g = -1;
        if (m_pkt[d]) begin
            g = m_own[d];
        end else begin
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (m_last[d] + k) % n;
                if (g < 0 && iv[c]) g = c;
            end
        end
        mask    = 4'((1 << n) - 1);
        space   = !m_ov[d] || ordy;
        exp_rdy = (space && g >= 0) ? 4'(1 << g) : 4'b0000;
        check({t, "_in_ready"}, ir & mask, exp_rdy);

        setv = 1'b0;
        if (space) begin
            if (g >= 0 && iv[g]) begin
                m_ov[d]  = 1'b1;
                m_od[d]  = idat[g*8 +: 8];
                m_os[d]  = isop[g];
                m_oe[d]  = ieop[g];
                m_och[d] = g;
                if (!m_pkt[d]) begin
                    m_last[d] = g;
                    setv      = !isop[g];
                end
                m_pkt[d] = !ieop[g];
                m_own[d] = g;
            end else begin
                m_ov[d] = 1'b0;
            end
        end
        m_err[d] = (m_err[d] && !clr) || setv;
    endtask

    // ---------------- compare process / scoreboard ----------------
    always @(negedge clk) begin
        model_cycle(0, 2, reset_n,
            {2'b00, bus2.in_valid}, {2'b00, bus2.in_ready},
            {2'b00, bus2.in_startofpacket}, {2'b00, bus2.in_endofpacket},
            {16'h0000, bus2.in_data}, bus2.out_ready,
            bus2.out_valid, bus2.out_data, bus2.out_startofpacket, bus2.out_endofpacket,
            bus2.out_channel, bus2.err_sop, bus2.err_nosop_clear);
        model_cycle(1, 4, reset_n,
            bus4.in_valid, bus4.in_ready, bus4.in_startofpacket, bus4.in_endofpacket,
            bus4.in_data, bus4.out_ready,
            bus4.out_valid, bus4.out_data, bus4.out_startofpacket, bus4.out_endofpacket,
            {6'b000000, bus4.out_channel}, bus4.err_sop, bus4.err_nosop_clear);

        if (reset_n && bus2.out_valid && bus2.out_ready) begin
            if (exp_q2.size() == 0) check("sb2_extra_beat", exp_q2.size(), 1);
            else check("sb2_beat", {bus2.out_channel, bus2.out_data}, exp_q2.pop_front());
        end
        if (reset_n && bus4.out_valid && bus4.out_ready) begin
            if (exp_q4.size() == 0) check("sb4_extra_beat", exp_q4.size(), 1);
            else check("sb4_beat", {6'b000000, bus4.out_channel, bus4.out_data}, {8'h00, exp_q4.pop_front()});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_out2(input logic [7:0] val, input string name);
        int t;
        t = 0;
        while (!(bus2.out_valid && bus2.out_data == val) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({name, "_timeout"}, t < 100, 1);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sources_busy() || exp_q2.size() != 0 || exp_q4.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drain"}, t < 300, 1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errs   = 0;
        for (int s = 0; s < 6; s++) begin
            src_len[s] = 0;
            src_pos[s] = 0;
        end
        reset_n = 1'b0;
        bus2.out_ready = 1'b1; bus2.err_nosop_clear = 1'b0;
        bus4.out_ready = 1'b1; bus4.err_nosop_clear = 1'b0;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // 1: 3-beat packet on input 0 while input 1 waits with a single beat.
        push_beat(0, 1, 0, 8'h11); push_beat(0, 0, 0, 8'h12); push_beat(0, 0, 1, 8'h13);
        push_beat(1, 1, 1, 8'hA0);
        exp_q2.push_back(16'h0011); exp_q2.push_back(16'h0012);
        exp_q2.push_back(16'h0013); exp_q2.push_back(16'h01A0);
        wait_out2(8'h12, "pkt_mid");
        check("pkt_mid_ready1", bus2.in_ready[1], 0);
        check("pkt_mid_locked", bus2.dbg_state, ST_LOCKED);
        drain("pkt");

        // 2: competing single-beat packets alternate.
        push_beat(0, 1, 1, 8'h01); push_beat(0, 1, 1, 8'h02);
        push_beat(1, 1, 1, 8'h81); push_beat(1, 1, 1, 8'h82);
        exp_q2.push_back(16'h0001); exp_q2.push_back(16'h0181);
        exp_q2.push_back(16'h0002); exp_q2.push_back(16'h0182);
        drain("alt");

        // 3: backpressure for three cycles in the middle of a packet.
        push_beat(0, 1, 0, 8'h21); push_beat(0, 0, 0, 8'h22);
        push_beat(0, 0, 0, 8'h23); push_beat(0, 0, 1, 8'h24);
        for (int i = 1; i <= 4; i++) exp_q2.push_back(16'(8'h20 + i));
        repeat (3) @(posedge clk);
        #1 bus2.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", bus2.out_valid, 1);
            check("stall_data", bus2.out_data, 8'h22);
            check("stall_ready", bus2.in_ready, 2'b00);
        end
        @(posedge clk);
        #1 bus2.out_ready = 1'b1;
        drain("stall");

        // 4: beat without SOP while unlocked sets the sticky error.
        push_beat(1, 0, 1, 8'h55);
        exp_q2.push_back(16'h0155);
        wait_out2(8'h55, "nosop");
        check("nosop_channel", bus2.out_channel, 8'h01);
        check("nosop_err_set", bus2.err_sop, 1);
        repeat (2) @(negedge clk);
        check("nosop_err_sticky", bus2.err_sop, 1);
        @(posedge clk);
        #1 bus2.err_nosop_clear = 1'b1;
        @(posedge clk);
        #1 bus2.err_nosop_clear = 1'b0;
        @(negedge clk);
        check("nosop_err_cleared", bus2.err_sop, 0);
        drain("nosop");

        // 5: reset while input 1 owns a 4-beat packet.
        push_beat(1, 1, 0, 8'h61); push_beat(1, 0, 0, 8'h62);
        push_beat(1, 0, 0, 8'h63); push_beat(1, 0, 1, 8'h64);
        for (int i = 1; i <= 4; i++) exp_q2.push_back(16'h0160 + 16'(i));
        wait_out2(8'h61, "rst_first");
        check("rst_locked", bus2.dbg_state, ST_LOCKED);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_valid", bus2.out_valid, 0);
        check("rst_async_data", bus2.out_data, 0);
        check("rst_async_channel", bus2.out_channel, 0);
        check("rst_async_eop", bus2.out_endofpacket, 0);
        src_pos[0] = src_len[0];
        src_pos[1] = src_len[1];
        exp_q2.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        push_beat(0, 1, 1, 8'h71);
        push_beat(1, 1, 1, 8'hE1);
        exp_q2.push_back(16'h0071); exp_q2.push_back(16'h01E1);
        wait_out2(8'h71, "post_rst");
        check("post_rst_channel", bus2.out_channel, 8'h00);
        drain("post_rst");

        // 6: four inputs, two single-beat packets each.
        for (int i = 0; i < 4; i++) begin
            push_beat(i + 2, 1, 1, 8'h40 + 8'(i));
            push_beat(i + 2, 1, 1, 8'h48 + 8'(i));
        end
        for (int i = 0; i < 4; i++) exp_q4.push_back({6'b000000, 2'(i), 8'h40 + 8'(i)});
        for (int i = 0; i < 4; i++) exp_q4.push_back({6'b000000, 2'(i), 8'h48 + 8'(i)});
        drain("four");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/avst_packet_channel_mux.md
Name: avst_packet_channel_mux

Overview:
- Parametrised Avalon-ST channel multiplexer: merges NUM_IN packet streams onto one output stream and tags each beat with its source index on out_channel.
- Successor to the single-input packet-to-channel adapter on the CSR master path. Adds fair arbitration, packet-atomic grant locking, a registered output stage and sticky protocol-error reporting.

Parameters:
- NUM_IN, 2, number of input streams; legal range 1..16.
- DATA_W, 8, data width per beat.
- CHANNEL_W, 8, width of out_channel; must be >= max(1, clog2(NUM_IN)).

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_IN  per-input valid.
- in_ready  output  NUM_IN  per-input ready; combinational.
- in_data  input  NUM_IN*DATA_W  input i occupies bits [i*DATA_W +: DATA_W].
- in_startofpacket  input  NUM_IN  per-input SOP.
- in_endofpacket  input  NUM_IN  per-input EOP.
- out_ready  input  1  downstream ready; readyLatency 0.
- out_valid  output  1  registered.
- out_data  output  DATA_W  registered.
- out_startofpacket  output  1  registered.
- out_endofpacket  output  1  registered.
- out_channel  output  CHANNEL_W  registered; index of the source input, zero-extended.
- err_sop  output  1  sticky: a beat without SOP was accepted while unlocked.
- err_nosop_clear  input  1  synchronous clear for err_sop.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0, err_sop=0, lock=0, rr_ptr=NUM_IN-1, so input 0 has first priority.
- Output stage is a single register. Let load = ~out_valid | out_ready.
- in_ready[i] = load & grant[i]. Only one grant bit is high per cycle.
- Accept on input i: in_valid[i] & in_ready[i]. On accept, the output register loads that beat's data/SOP/EOP and out_channel=i, and out_valid=1.
- If load is high and there is no accept, out_valid goes to 0.
- Latency is 1 cycle. Throughput is 1 beat/cycle while out_ready stays high.
- Output register holds its value while out_valid & ~out_ready.
- State UNLOCKED:
  - grant goes to the first input with in_valid high, searching in order rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
  - The grant is computed combinationally from registered state.
- Accept while UNLOCKED:
  - rr_ptr takes the granted index.
  - If the beat has SOP & ~EOP, go to LOCKED(owner=i).
  - If SOP & EOP (single-beat packet), stay UNLOCKED.
  - If ~SOP: set err_sop, forward the beat anyway. Lock if ~EOP, otherwise stay UNLOCKED.
- State LOCKED(owner):
  - grant = owner only. Other inputs see in_ready=0 even when owner's in_valid is low.
  - Accept with EOP returns to UNLOCKED.
  - An accepted SOP beat from the owner while LOCKED is forwarded unchanged. It does not set err_sop, and the lock continues.
- Simultaneous requests: exactly one grant; no beat is dropped or duplicated.
- NUM_IN=1: the arbiter degenerates; out_channel is always 0.
- err_sop: if set and clear occur in the same cycle, set wins. err_sop is not cleared by EOP.
- Reset mid-packet: the lock is released and the partial packet is not completed on the output. The upstream is responsible for resending.
- in_data, SOP and EOP are ignored when in_valid is low. Output fields are don't-care while out_valid=0, but the register holds its last value.

Decomposition:
- Shared package avst_pkg holds:
  - function clog2;
  - localparam MAX_NUM_IN=16;
  - typedef of the state encoding (UNLOCKED, LOCKED).
- Natural sub-module: avst_rr_arbiter (NUM_IN).
  - Inputs: req vector, rr_ptr, lock, owner.
  - Output: one-hot grant plus encoded index.
  - Purely combinational.
- The top level holds the lock/owner/rr_ptr registers, the output register and err_sop.

Test Plan:
- NUM_IN=2, DATA_W=8, CHANNEL_W=8, out_ready=1. Input 0 sends a 3-beat packet 0x11/0x12/0x13 while input 1 holds valid with 0xA0 SOP+EOP.
  - Output: 0x11,0x12,0x13 with channel 0x00, then 0xA0 with channel 0x01.
  - in_ready[1]=0 for the whole packet on input 0.
- Both inputs send back-to-back single-beat packets (in 0: 0x01,0x02; in 1: 0x81,0x82).
  - Output order: 0x01(ch0), 0x81(ch1), 0x02(ch0), 0x82(ch1). Strict alternation, one beat/cycle.
- Backpressure: out_ready=0 for 3 cycles mid-packet.
  - out_data is held stable and in_ready=0 throughout.
  - After release, no beat is lost or duplicated; total beat count matches.
- Input 1 beat 0x55 without SOP while UNLOCKED.
  - Forwarded with ch1, err_sop=1 the next cycle, and it stays 1.
  - err_nosop_clear pulse -> err_sop=0.
- Reset_n asserted while LOCKED to input 1 after 1 of 4 beats.
  - Outputs are 0 immediately (async).
  - After release, input 0 is granted first even when both inputs are valid.
- NUM_IN=4, CHANNEL_W=2, all inputs valid with single-beat packets.
  - Output channels cycle 0,1,2,3,0; out_channel width is 2.
